gf_div_seq: RTL

GF_DIV_SEQ -- requirements
Module: gf_div_seq

---
 rtl/gf_div_seq.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/gf_div_seq.sv
// Sequential GF(2^8) divider: q = a * b^254 by square-and-multiply, one step per cycle.
// Optional zero-divisor flag output enabled by defining GF_DIV_ZERO_FLAG_EN.
module gf_div_seq #(
    parameter logic [8:0] FIELD_POLY = 9'h11B
) (
    input  logic       in_clock,
    input  logic       in_reset_n,
    input  logic       in_valid,
    output logic       out_ready,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    output logic       out_valid,
    input  logic       in_ready,
    output logic [7:0] out_q
`ifdef GF_DIV_ZERO_FLAG_EN
    ,
    output logic       out_div_zero
`endif
);

    localparam int unsigned W         = 8;
    localparam int unsigned CNT_W     = 3;
    localparam int unsigned LAST_STEP = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [W-1:0]     r_a;
    logic [W-1:0]     w_a_nxt;
    logic [W-1:0]     r_b;
    logic [W-1:0]     w_b_nxt;
    logic [W-1:0]     r_r;
    logic [W-1:0]     w_r_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_ready;
    logic             w_ready_nxt;
    logic [W-1:0]     w_m;
    logic [W-1:0]     w_sq;
    logic [W-1:0]     w_step;
`ifdef GF_DIV_ZERO_FLAG_EN
    logic             r_dz;
    logic             w_dz_nxt;
`endif

    // Shift-and-add multiply in GF(2^8), reducing by FIELD_POLY on every shift.
    function automatic logic [W-1:0] gf_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] acc;
        logic [W-1:0] sh;
        acc = '0;
        sh  = x;
        for (int i = 0; i < int'(W); i++) begin
            if (y[i]) begin
                acc = acc ^ sh;
            end
            if (sh[W-1]) begin
                sh = {sh[W-2:0], 1'b0} ^ FIELD_POLY[W-1:0];
            end else begin
                sh = {sh[W-2:0], 1'b0};
            end
        end
        return acc;
    endfunction

    // Steps 0..5 build b^127 (exponent chain 1,3,7,...), the last step squares and folds in a.
    assign w_m    = (r_cnt == CNT_W'(LAST_STEP)) ? r_a : r_b;
    assign w_sq   = gf_mul(r_r, r_r);
    assign w_step = gf_mul(w_sq, w_m);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_r_nxt     = r_r;
        w_valid_nxt = 1'b0;
`ifdef GF_DIV_ZERO_FLAG_EN
        w_dz_nxt    = r_dz;
`endif
        case (r_state)
            S_IDLE: begin
                if (in_valid && r_ready) begin
                    w_a_nxt     = in_a;
                    w_b_nxt     = in_b;
                    w_r_nxt     = in_b;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_BUSY;
`ifdef GF_DIV_ZERO_FLAG_EN
                    w_dz_nxt    = (in_b == '0);
`endif
                end
            end
            S_BUSY: begin
                w_r_nxt   = w_step;
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(LAST_STEP)) begin
                    w_state_nxt = S_DONE;
                    w_valid_nxt = 1'b1;
                end
            end
            S_DONE: begin
                w_valid_nxt = 1'b1;
                if (in_ready) begin
                    w_state_nxt = S_IDLE;
                    w_valid_nxt = 1'b0;
`ifdef GF_DIV_ZERO_FLAG_EN
                    w_dz_nxt    = 1'b0;
`endif
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_ready_nxt = (w_state_nxt == S_IDLE);
    end

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_r     <= '0;
            r_valid <= 1'b0;
            r_ready <= 1'b0;
`ifdef GF_DIV_ZERO_FLAG_EN
            r_dz    <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_r     <= w_r_nxt;
            r_valid <= w_valid_nxt;
            r_ready <= w_ready_nxt;
`ifdef GF_DIV_ZERO_FLAG_EN
            r_dz    <= w_dz_nxt;
`endif
        end
    end

    assign out_ready = r_ready;
    assign out_valid = r_valid;
    assign out_q     = r_r;
`ifdef GF_DIV_ZERO_FLAG_EN
    assign out_div_zero = r_dz;
`endif

endmodule
